// File: rtl/pq_stimgen.sv
// Stimulus producer for the priority-queue harness: fills the queue with LFSR keys
// ending in an 8'hFF sentinel, then drains it while enabling the ordering checker.
module pq_stimgen #(
  parameter int             DW    = 8,
  parameter int             NKEYS = 16,
  parameter logic [DW-1:0]  SEED  = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          full,
  input  logic          empty,
  output logic          enq,
  output logic [DW-1:0] kout,
  output logic          deq,
  output logic          chk_enb,
  output logic          busy,
  output logic          done,
  output logic [7:0]    pushed,
  output logic [7:0]    popped
);

  localparam logic [DW-1:0] SEED_EFF = (SEED == '0) ? DW'(1) : SEED;
  localparam logic [DW-1:0] MASK     = DW'(8'hB8);
  localparam logic [DW-1:0] SENTINEL = {DW{1'b1}};
  localparam logic [DW-1:0] KEY_ALT  = SENTINEL - DW'(1);
  localparam logic [7:0]    NK       = 8'(NKEYS);
  localparam logic [7:0]    NK_LAST  = 8'(NKEYS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] lfsr_reg, lfsr_next;
  logic [DW-1:0] kout_reg, kout_next;
  logic [7:0]    pushed_reg, pushed_next;
  logic [7:0]    popped_reg, popped_next;
  logic          enq_reg, enq_next;
  logic          deq_reg, deq_next;
  logic          chk_reg, chk_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic          run_start;
  logic          do_push;
  logic          do_pop;
  logic          last_key;
  logic [7:0]    push_base;
  logic [DW-1:0] lfsr_step;
  logic [DW-1:0] key_rand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      lfsr_reg   <= SEED_EFF;
      kout_reg   <= '0;
      pushed_reg <= '0;
      popped_reg <= '0;
      enq_reg    <= 1'b0;
      deq_reg    <= 1'b0;
      chk_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lfsr_reg   <= lfsr_next;
      kout_reg   <= kout_next;
      pushed_reg <= pushed_next;
      popped_reg <= popped_next;
      enq_reg    <= enq_next;
      deq_reg    <= deq_next;
      chk_reg    <= chk_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (pushed_reg == NK) state_next = DRAIN;
      DRAIN:   if (popped_reg == NK) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The start edge doubles as the first fill decision so enq follows start by one cycle.
  always_comb begin
    run_start = (state_reg == IDLE) && start;
    push_base = run_start ? 8'd0 : pushed_reg;
    do_push   = !full && (run_start || ((state_reg == FILL) && (pushed_reg != NK)));
    last_key  = (push_base == NK_LAST);
    do_pop    = (state_reg == DRAIN) && !empty && (popped_reg != NK);
    lfsr_step = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? MASK : '0);
    key_rand  = (lfsr_reg == SENTINEL) ? KEY_ALT : lfsr_reg;

    enq_next    = do_push;
    kout_next   = kout_reg;
    lfsr_next   = lfsr_reg;
    pushed_next = push_base + 8'(do_push);
    if (do_push) begin
      kout_next = last_key ? SENTINEL : key_rand;
      if (!last_key) lfsr_next = lfsr_step;
    end

    popped_next = run_start ? 8'd0 : popped_reg + 8'(do_pop);
    deq_next    = do_pop;
    chk_next    = (state_next == DRAIN) || (state_next == DONE);
    busy_next   = (state_next == FILL) || (state_next == DRAIN);
    done_next   = (state_next == DONE);
  end

  assign enq     = enq_reg;
  assign kout    = kout_reg;
  assign deq     = deq_reg;
  assign chk_enb = chk_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign pushed  = pushed_reg;
  assign popped  = popped_reg;

endmodule

// File: tb/tb_pq_stimgen.sv
// Bench for pq_stimgen: cycle table for two directed runs, async reset mid-drain,
// then randomized full/empty runs against a key-list scoreboard.
module tb_pq_stimgen;

  localparam int NK = 4;

  logic       clk = 1'b0;
  logic       rst, start, full, empty;
  logic       enq, deq, chk_enb, busy, done;
  logic [7:0] kout, pushed, popped;

  pq_stimgen #(.DW(8), .NKEYS(NK), .SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .full(full), .empty(empty),
    .enq(enq), .kout(kout), .deq(deq), .chk_enb(chk_enb), .busy(busy),
    .done(done), .pushed(pushed), .popped(popped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr;

  typedef struct {
    logic       start, full, empty;
    logic       enq;
    logic [7:0] kout;
    logic       deq, chk, busy, done;
    logic [7:0] pushed, popped;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, f, e, en, input logic [7:0] k,
                              input logic dq, ck, bz, dn, input logic [7:0] pu, po);
    vec_t v;
    v.start = s; v.full = f; v.empty = e; v.enq = en; v.kout = k; v.deq = dq;
    v.chk = ck; v.busy = bz; v.done = dn; v.pushed = pu; v.popped = po;
    return v;
  endfunction

  function automatic logic [28:0] pack_out();
    return {enq, kout, deq, chk_enb, busy, done, pushed, popped};
  endfunction

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
    return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [7:0] key_map(input logic [7:0] l);
    return (l == 8'hFF) ? 8'hFE : l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full run against the scoreboard; pf/pe/ps are percent chances of full, empty, stray start.
  task automatic run_model(input int run_id, input int pf, input int pe, input int ps,
                           output logic [7:0] first_key);
    logic [7:0] exp_keys[$];
    int   n_enq = 0, n_deq = 0, cyc = 0;
    logic pf_prev, pe_prev, finished = 1'b0;
    first_key = 8'h00;
    for (int i = 0; i < NK - 1; i++) begin
      exp_keys.push_back(key_map(m_lfsr));
      m_lfsr = lfsr_adv(m_lfsr);
    end
    exp_keys.push_back(8'hFF);
    start = 1'b1;
    full  = (int'($urandom_range(99)) < pf);
    empty = 1'b0;
    while (!finished && cyc < 400) begin
      pf_prev = full;
      pe_prev = empty;
      step();
      cyc++;
      start = 1'b0;
      check("enq_guard", {31'd0, enq & pf_prev}, 0);
      check("deq_guard", {31'd0, deq & pe_prev}, 0);
      check("strobe_overlap", {31'd0, enq & deq}, 0);
      check("chk_during_deq", {31'd0, deq & ~chk_enb}, 0);
      if (enq) begin
        if (n_enq >= NK) check("extra_enq", n_enq, NK - 1);
        else begin
          if (n_enq == 0) first_key = kout;
          check("kout", {24'd0, kout}, {24'd0, exp_keys[n_enq]});
        end
        n_enq++;
      end
      if (deq) begin
        check("deq_before_fill_end", n_enq, NK);
        n_deq++;
      end
      check("pushed", {24'd0, pushed}, n_enq);
      check("popped", {24'd0, popped}, n_deq);
      if (done) begin
        check("done_enq_total", n_enq, NK);
        check("done_deq_total", n_deq, NK);
        check("done_busy", {31'd0, busy}, 0);
        check("done_chk", {31'd0, chk_enb}, 1);
        finished = 1'b1;
      end
      full  = (int'($urandom_range(99)) < pf);
      empty = (int'($urandom_range(99)) < pe);
      start = busy && (int'($urandom_range(99)) < ps);
    end
    start = 1'b0;
    if (!finished) check("run_timeout", 0, 1);
    step();
    check("post_done", {30'd0, done, chk_enb}, 0);
    $display("run %0d enq=%0d deq=%0d cycles=%0d", run_id, n_enq, n_deq, cyc);
  endtask

  initial begin
    logic [7:0] fk;
    int budget;

    // Directed run 1: NKEYS=4 from SEED A5, no stalls.
    tbl[0]  = mk(1,0,0, 1,8'hA5,0,0,1,0,8'd1,8'd0);
    tbl[1]  = mk(0,0,0, 1,8'hEA,0,0,1,0,8'd2,8'd0);
    tbl[2]  = mk(0,0,0, 1,8'h75,0,0,1,0,8'd3,8'd0);
    tbl[3]  = mk(0,0,0, 1,8'hFF,0,0,1,0,8'd4,8'd0);
    tbl[4]  = mk(0,0,0, 0,8'hFF,0,1,1,0,8'd4,8'd0);
    tbl[5]  = mk(0,0,0, 0,8'hFF,1,1,1,0,8'd4,8'd1);
    tbl[6]  = mk(0,0,0, 0,8'hFF,1,1,1,0,8'd4,8'd2);
    tbl[7]  = mk(0,0,0, 0,8'hFF,1,1,1,0,8'd4,8'd3);
    tbl[8]  = mk(0,0,0, 0,8'hFF,1,1,1,0,8'd4,8'd4);
    tbl[9]  = mk(0,0,0, 0,8'hFF,0,1,0,1,8'd4,8'd4);
    tbl[10] = mk(0,0,0, 0,8'hFF,0,0,0,0,8'd4,8'd4);
    // Directed run 2: LFSR continues at 82; full stall x3, stray starts, empty stall x2.
    tbl[11] = mk(1,0,0, 1,8'h82,0,0,1,0,8'd1,8'd0);
    tbl[12] = mk(0,1,0, 0,8'h82,0,0,1,0,8'd1,8'd0);
    tbl[13] = mk(0,1,0, 0,8'h82,0,0,1,0,8'd1,8'd0);
    tbl[14] = mk(0,1,0, 0,8'h82,0,0,1,0,8'd1,8'd0);
    tbl[15] = mk(1,0,0, 1,8'h41,0,0,1,0,8'd2,8'd0);
    tbl[16] = mk(1,0,0, 1,8'h98,0,0,1,0,8'd3,8'd0);
    tbl[17] = mk(0,0,0, 1,8'hFF,0,0,1,0,8'd4,8'd0);
    tbl[18] = mk(0,0,0, 0,8'hFF,0,1,1,0,8'd4,8'd0);
    tbl[19] = mk(0,0,0, 0,8'hFF,1,1,1,0,8'd4,8'd1);
    tbl[20] = mk(0,0,1, 0,8'hFF,0,1,1,0,8'd4,8'd1);
    tbl[21] = mk(0,0,1, 0,8'hFF,0,1,1,0,8'd4,8'd1);
    tbl[22] = mk(0,0,0, 0,8'hFF,1,1,1,0,8'd4,8'd2);
    tbl[23] = mk(0,0,0, 0,8'hFF,1,1,1,0,8'd4,8'd3);
    tbl[24] = mk(0,0,0, 0,8'hFF,1,1,1,0,8'd4,8'd4);
    tbl[25] = mk(0,0,0, 0,8'hFF,0,1,0,1,8'd4,8'd4);
    tbl[26] = mk(0,0,0, 0,8'hFF,0,0,0,0,8'd4,8'd4);

    rst = 1'b1; start = 1'b0; full = 1'b0; empty = 1'b0;
    #12 rst = 1'b0;
    step();
    check("reset_state", {3'd0, pack_out()}, 0);

    for (int i = 0; i < 27; i++) begin
      start = tbl[i].start;
      full  = tbl[i].full;
      empty = tbl[i].empty;
      step();
      check($sformatf("row%0d", i), {3'd0, pack_out()},
            {3'd0, tbl[i].enq, tbl[i].kout, tbl[i].deq, tbl[i].chk, tbl[i].busy,
             tbl[i].done, tbl[i].pushed, tbl[i].popped});
      $display("row %0d out=%h", i, pack_out());
    end
    start = 1'b0; full = 1'b0; empty = 1'b0;

    // Async reset in the middle of a drain, away from any clock edge.
    start = 1'b1;
    step();
    start = 1'b0;
    budget = 0;
    while (popped != 8'd2 && budget < 60) begin
      step();
      budget++;
    end
    check("reach_mid_drain", {24'd0, popped}, 2);
    #3 rst = 1'b1;
    #1 check("async_reset_outputs", {3'd0, pack_out()}, 0);
    #2 rst = 1'b0;
    $display("async reset applied mid-drain");

    m_lfsr = 8'hA5;
    run_model(0, 0, 0, 0, fk);
    check("replay_first_key", {24'd0, fk}, 32'hA5);

    for (int r = 1; r <= 100; r++) begin
      run_model(r, 30, 30, 10, fk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
